// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, state encoding and queue entry type for the instruction fetch stage.
// Also holds the ROM range test used by both the PC and redirect logic.
package inst_fetch_queue_pkg;

  localparam int INST_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic {
    FETCH = 1'b0,
    END   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Widened by one bit so that pc values near 2^32 cannot wrap into range.
  function automatic logic pc_in_range(input logic [ADDR_W-1:0] pc,
                                       input int unsigned       rom_bytes);
    return ({1'b0, pc} + (ADDR_W+1)'(PC_STEP)) <= (ADDR_W+1)'(rom_bytes);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_queue.sv
// In-order FIFO of fetched {pc, inst} entries; flush clears the pointers and has priority.
// The caller never pushes into a full queue unless it pops in the same cycle.
module inst_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               din,
  input  logic                       pop,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[head];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, reads the instruction ROM and buffers {pc, inst} for issue.
// A redirect flushes the queue and reloads the PC; fetching stops at the end of the ROM.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] PC_RESET  = 32'h0,
  parameter int unsigned       ROM_BYTES = 100
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_nrd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic              issue_valid,
  output logic [INST_W-1:0] issue_inst,
  output logic [ADDR_W-1:0] issue_pc,
  input  logic              issue_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_target;
  logic [CNT_W-1:0]  count;
  logic              in_range;
  logic              queue_nonempty;
  logic              pop;
  logic              fetch_en;
  fetch_entry_t      head_entry;
  fetch_entry_t      new_entry;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign in_range        = pc_in_range(pc, ROM_BYTES);
  assign queue_nonempty  = (count != '0);
  assign issue_valid     = queue_nonempty && !redirect_valid;
  assign pop             = issue_valid && issue_ready;
  assign new_entry       = '{pc: pc, inst: rom_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= PC_RESET;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc <= redirect_target;
      end else if (fetch_en) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    fetch_en   = 1'b0;
    fetch_done = 1'b0;
    case (state)
      FETCH: begin
        // rst gates the strobe so the ROM is never read while reset is held.
        fetch_en = !rst && in_range && !redirect_valid &&
                   ((count < CNT_W'(DEPTH)) || pop);
        if (!in_range) state_next = END;
      end
      END: begin
        fetch_done = 1'b1;
      end
      default: state_next = FETCH;
    endcase
    if (redirect_valid) begin
      state_next = pc_in_range(redirect_target, ROM_BYTES) ? FETCH : END;
    end
  end

  inst_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fetch_en),
    .din   (new_entry),
    .pop   (pop),
    .dout  (head_entry),
    .count (count)
  );

  assign rom_nrd    = !fetch_en;
  assign rom_addr   = pc;
  assign issue_inst = queue_nonempty ? head_entry.inst : '0;
  assign issue_pc   = queue_nonempty ? head_entry.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a vector table for reset/stream/backpressure/redirect,
// then hand-written sequences for end of ROM, full push+pop and asynchronous reset.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        issue_valid;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic        issue_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    logic        exp_nrd;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_queue #(
    .DEPTH     (4),
    .PC_RESET  (32'h0),
    .ROM_BYTES (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_nrd        (rom_nrd),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .issue_valid    (issue_valid),
    .issue_inst     (issue_inst),
    .issue_pc       (issue_pc),
    .issue_ready    (issue_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_done     (fetch_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  always_comb rom_data = w(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic v, input logic [31:0] ipc, input logic [31:0] inst,
                     input logic [31:0] addr, input logic nrd, input logic done);
    vec_t t;
    t = '{rst: r, ready: rdy, redir: rv, rpc: rpc, exp_valid: v, exp_pc: ipc,
          exp_inst: inst, exp_addr: addr, exp_nrd: nrd, exp_done: done};
    vecs.push_back(t);
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; issue_ready = rdy;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          issued;
    logic [31:0] exp_pc;
    logic [31:0] last_fetch;
    logic        seen_done;

    //  rst rdy rv rpc   valid pc  inst    addr nrd done
    add(1, 1, 0, 0,     0, 0,  0,      0,  1, 0);   // held in reset
    add(0, 1, 0, 0,     0, 0,  0,      0,  0, 0);   // streaming
    add(0, 1, 0, 0,     1, 0,  w(0),   4,  0, 0);
    add(0, 1, 0, 0,     1, 4,  w(4),   8,  0, 0);
    add(0, 1, 0, 0,     1, 8,  w(8),   12, 0, 0);
    add(0, 1, 0, 0,     1, 12, w(12),  16, 0, 0);
    add(1, 1, 0, 0,     0, 0,  0,      0,  1, 0);   // reset mid-stream
    add(0, 0, 0, 0,     0, 0,  0,      0,  0, 0);   // backpressure fill
    add(0, 0, 0, 0,     1, 0,  w(0),   4,  0, 0);
    add(0, 0, 0, 0,     1, 0,  w(0),   8,  0, 0);
    add(0, 0, 0, 0,     1, 0,  w(0),   12, 0, 0);
    add(0, 0, 0, 0,     1, 0,  w(0),   16, 1, 0);   // full, pc held
    add(0, 0, 0, 0,     1, 0,  w(0),   16, 1, 0);
    add(0, 1, 0, 0,     1, 0,  w(0),   16, 0, 0);   // pop frees a slot same cycle
    add(0, 1, 0, 0,     1, 4,  w(4),   20, 0, 0);
    add(0, 1, 0, 0,     1, 8,  w(8),   24, 0, 0);
    add(0, 1, 0, 0,     1, 12, w(12),  28, 0, 0);
    add(0, 1, 0, 0,     1, 16, w(16),  32, 0, 0);
    add(1, 0, 0, 0,     0, 0,  0,      0,  1, 0);   // reset, then queue three
    add(0, 0, 0, 0,     0, 0,  0,      0,  0, 0);
    add(0, 0, 0, 0,     1, 0,  w(0),   4,  0, 0);
    add(0, 0, 0, 0,     1, 0,  w(0),   8,  0, 0);
    add(0, 0, 1, 42,    0, 0,  w(0),   12, 1, 0);   // redirect pulse
    add(0, 0, 0, 0,     0, 0,  0,      40, 0, 0);
    add(0, 0, 0, 0,     1, 40, w(40),  44, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      issue_ready    = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d issue_pc", i),    issue_pc,         vecs[i].exp_pc);
      check($sformatf("v%0d issue_inst", i),  issue_inst,       vecs[i].exp_inst);
      check($sformatf("v%0d rom_addr", i),    rom_addr,         vecs[i].exp_addr);
      check($sformatf("v%0d rom_nrd", i),     32'(rom_nrd),     32'(vecs[i].exp_nrd));
      check($sformatf("v%0d fetch_done", i),  32'(fetch_done),  32'(vecs[i].exp_done));
    end
    redirect_valid = 1'b0;

    // End of ROM: stream everything, expect last fetch at 96 and a full drain.
    do_reset(1'b1);
    exp_pc = 0; issued = 0; last_fetch = 32'hFFFF_FFFF; seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      #1;
      if (issue_valid) begin
        check("eor issue_pc", issue_pc, exp_pc);
        check("eor issue_inst", issue_inst, w(exp_pc));
        exp_pc += 4;
        issued++;
      end
      if (!rom_nrd) last_fetch = rom_addr;
      if (fetch_done) seen_done = 1'b1;
    end
    check("eor fetch_done seen", 32'(seen_done), 1);
    check("eor last fetch", last_fetch, 96);
    check("eor rom_nrd", 32'(rom_nrd), 1);
    check("eor pc held", rom_addr, 100);
    for (int c = 0; c < 8 && issue_valid; c++) begin
      @(negedge clk);
      #1;
      if (issue_valid) begin
        check("eor drain pc", issue_pc, exp_pc);
        exp_pc += 4;
        issued++;
      end
    end
    check("eor drained", 32'(issue_valid), 0);
    check("eor issued count", 32'(issued), 25);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    #1;
    check("eor done during redirect", 32'(fetch_done), 1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("eor done cleared", 32'(fetch_done), 0);
    check("eor resume addr", rom_addr, 8);
    check("eor resume nrd", 32'(rom_nrd), 0);
    @(negedge clk);
    #1;
    check("eor resume valid", 32'(issue_valid), 1);
    check("eor resume pc", issue_pc, 8);

    // Full queue with simultaneous push and pop for 10 cycles.
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    issue_ready = 1'b1;
    exp_pc = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("full count c%0d", i), 32'(dut.count), 4);
      check($sformatf("full nrd c%0d", i), 32'(rom_nrd), 0);
      check($sformatf("full pc c%0d", i), issue_pc, exp_pc);
      exp_pc += 4;
      @(negedge clk);
    end

    // Asynchronous reset asserted between edges.
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async valid", 32'(issue_valid), 0);
    check("async addr", rom_addr, 0);
    check("async nrd", 32'(rom_nrd), 1);
    check("async issue_pc", issue_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async rel valid", 32'(issue_valid), 0);
    check("async rel addr", rom_addr, 0);
    check("async rel nrd", 32'(rom_nrd), 0);
    @(negedge clk);
    #1;
    check("async restart valid", 32'(issue_valid), 1);
    check("async restart pc", issue_pc, 0);
    check("async restart inst", issue_inst, w(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch stage for the Tomasulo core. It owns the program counter and drives the instruction ROM's read port (active-low read strobe, byte address, 32-bit big-endian word returned combinationally in the same cycle). It buffers fetched words with their PCs in a small in-order queue and presents them to the issue stage through a valid/ready handshake. On a branch redirect from the back end it flushes the queue and resumes fetching at the new PC.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- PC_RESET, 32'h0: PC loaded on reset.
- ROM_BYTES, 100: ROM size in bytes. A fetch is legal only when pc + 4 <= ROM_BYTES.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_nrd  out  1  ROM read strobe, active low.
- rom_addr  out  32  ROM byte address; always equals pc.
- rom_data  in  32  ROM word; valid in the same cycle that rom_nrd = 0.
- issue_valid  out  1  head entry available.
- issue_inst  out  32  head instruction; 0 when the queue is empty.
- issue_pc  out  32  PC of the head instruction; 0 when the queue is empty.
- issue_ready  in  1  issue stage accepts the head entry this cycle.
- redirect_valid  in  1  flush the queue and reload the PC.
- redirect_pc  in  32  new PC; bits [1:0] are forced to 0.
- fetch_done  out  1  high while in state END.

## Operation
- States:
  - FETCH: the default after reset.
  - END: entered when the current pc + 4 > ROM_BYTES, evaluated combinationally each cycle in FETCH.
- In END:
  - rom_nrd = 1 and pc holds.
  - The queue still drains to the issue stage.
  - A redirect moves the block to FETCH if the new PC is in range; otherwise it stays in END with the new PC.
- pop = issue_valid & issue_ready.
- issue_valid = (count != 0) & ~redirect_valid.
- fetch_en = state FETCH & in-range & ~redirect_valid & (count < DEPTH | pop).
- rom_nrd = ~fetch_en.
- On a rising edge with fetch_en: write {pc, rom_data} at the tail, then pc <= pc + 4. The PC addition is 32-bit modulo; no other wrap.
- Simultaneous push and pop when the queue is full: count stays DEPTH and both pointers advance.
- Redirect has priority over everything else:
  - count, head and tail are cleared.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop happen that cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset values:
  - pc = PC_RESET; count, head and tail = 0; state = FETCH.
  - Outputs: issue_valid = 0, issue_inst = 0, issue_pc = 0.
  - rom_addr = PC_RESET.
  - rom_nrd = 1 while rst is high, then follows fetch_en.
  - fetch_done = 0, unless PC_RESET is out of range, in which case END is entered on the first cycle after reset.
- Reset asserted mid-operation discards all queued entries immediately (asynchronous).

## Timing
- ROM access has zero added latency: a word is fetched in cycle t and appears at the queue head in cycle t+1 if the queue was empty.
- Throughput is one instruction per cycle when issue_ready is held high.
- Redirect in cycle t: the new PC is fetched in t+1, and issue_valid with issue_pc = new PC is seen in t+2.
- Full queue with no pop: rom_nrd = 1 and pc holds. Fetch resumes in the same cycle that a pop occurs.
- issue_inst and issue_pc are read combinationally from the head storage entry; no output register.

## Structure
- Shared defines header holds INST_W = 32, ADDR_W = 32, PC_STEP = 4, and the state encodings FETCH = 1'b0 and END = 1'b1. The issue and ROM blocks reuse the width constants.
- One natural sub-module: inst_queue, a synchronous FIFO with push/pop/flush, count output and DEPTH parameter. inst_fetch_queue contains the PC, the state machine and the ROM/issue glue.

## Test plan
- Streaming: release reset with issue_ready = 1 and the ROM preloaded with words W0..W4.
  - rom_addr sequence is 0, 4, 8, …
  - First issue_valid comes one cycle after reset release, with issue_pc = 0 and issue_inst = W0, then one instruction per cycle.
- Backpressure: issue_ready = 0 after reset.
  - Four pushes fill the queue, then rom_nrd = 1 with pc held at 16.
  - Raise issue_ready: pops W0..W3 in order, and the fetch of pc 16 occurs in the first pop cycle.
- Redirect: with 3 entries queued, pulse redirect_valid with redirect_pc = 42.
  - issue_valid is low in that cycle, and count = 0 next cycle.
  - rom_addr = 40 in the next cycle, and issue_pc = 40 two cycles after the pulse.
- End of ROM: ROM_BYTES = 100, streaming.
  - Last fetch is at pc 96; then fetch_done = 1, rom_nrd = 1 and pc = 100.
  - The queue drains fully.
  - A redirect to 8 clears fetch_done and resumes fetching at 8.
- Full with simultaneous push and pop: count stays 4 over 10 cycles, and the issued PCs are consecutive multiples of 4.
- Asynchronous reset mid-stream: assert rst between clock edges.
  - issue_valid = 0 and rom_addr = PC_RESET immediately.
  - After release, fetching restarts at PC_RESET with no stale entries.
